// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian data memory with sized B/H/W/D loads and stores and a 1-cycle registered response.
// Macro DMEM_MISALIGN_SPLIT_EN: word-spanning accesses take a 2-cycle SPLIT path (ready low 1 cycle); otherwise they return an error.
module data_mem_sized #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 17,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] INIT_BASE = 32'h10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int IDXW  = ADDR_W - OFFW;
  localparam int DEPTH = 2 ** IDXW;

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
`else
  typedef enum logic {IDLE = 1'b0} state_t;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;

  logic [3:0]        nbytes;
  logic [OFFW-1:0]   off;
  logic [IDXW-1:0]   idx;
  logic [ADDR_W:0]   end_excl;
  logic              span, err_range, err_size, err_any;
  logic [NB-1:0]     bmask, lo_be;
  logic [DATA_W-1:0] lo_dat;

  logic              accept, wr_en, rd_en, rsp_set;
  logic [IDXW-1:0]   wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_dat;
  logic [NB-1:0]     wr_be;

  logic              rsp_err_q, rsp_we_q, rsp_uns_q;
  logic [1:0]        rsp_size_q;
  logic [OFFW-1:0]   rsp_off_q;
  logic [DATA_W-1:0] rd_lo;

  logic [3:0]        nb_q;
  logic [DATA_W-1:0] raw, load_dat;
  logic              sign, ext;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [NB-1:0]     hi_be, sp_be;
  logic [DATA_W-1:0] hi_dat, sp_dat, rd_hi;
  logic [IDXW-1:0]   sp_idx;
  logic              sp_we, rd_hi_sel;
`endif

  always_comb begin
    nbytes    = 4'd1 << req_size;
    off       = req_addr[OFFW-1:0];
    idx       = req_addr[ADDR_W-1:OFFW];
    end_excl  = {1'b0, req_addr[ADDR_W-1:0]} + {{(ADDR_W-3){1'b0}}, nbytes};
    err_range = (req_addr[31:ADDR_W] != '0) || (end_excl > {1'b1, {ADDR_W{1'b0}}});
    err_size  = (DATA_W == 32) && (req_size == 2'b11);
    span      = (int'(off) + int'(nbytes)) > NB;
`ifdef DMEM_MISALIGN_SPLIT_EN
    err_any   = err_range || err_size;
`else
    err_any   = err_range || err_size || span;
`endif
    bmask = '0;
    for (int b = 0; b < NB; b++) bmask[b] = (b < int'(nbytes));
    lo_dat = req_wdata << {off, 3'b000};
    lo_be  = bmask << off;
`ifdef DMEM_MISALIGN_SPLIT_EN
    // Bytes that fall past the word boundary; shifting by a full word yields zero.
    hi_dat = req_wdata >> (8 * (NB - int'(off)));
    hi_be  = bmask >> (NB - int'(off));
`endif
  end

  always_comb begin
    state_nxt = state;
    accept    = req_valid && req_ready;
    wr_en     = 1'b0;
    wr_idx    = idx;
    wr_dat    = lo_dat;
    wr_be     = lo_be;
    rd_en     = 1'b0;
    rd_idx    = idx;
    rsp_set   = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    rd_hi_sel = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          wr_en = req_we && !err_any;
          rd_en = !req_we && !err_any;
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (span && !err_any) state_nxt = SPLIT;
          else                  rsp_set   = 1'b1;
`else
          rsp_set = 1'b1;
`endif
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      SPLIT: begin
        wr_en     = sp_we;
        wr_idx    = sp_idx;
        wr_dat    = sp_dat;
        wr_be     = sp_be;
        rd_en     = !sp_we;
        rd_idx    = sp_idx;
        rd_hi_sel = 1'b1;
        rsp_set   = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_we_q   <= 1'b0;
      rsp_uns_q  <= 1'b0;
      rsp_size_q <= 2'b00;
      rsp_off_q  <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      sp_idx     <= '0;
      sp_dat     <= '0;
      sp_be      <= '0;
      sp_we      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= rsp_set;
      if (accept) begin
        rsp_err_q  <= err_any;
        rsp_we_q   <= req_we;
        rsp_uns_q  <= req_unsigned;
        rsp_size_q <= req_size;
        rsp_off_q  <= off;
`ifdef DMEM_MISALIGN_SPLIT_EN
        sp_idx     <= idx + IDXW'(1);
        sp_dat     <= hi_dat;
        sp_be      <= hi_be;
        sp_we      <= req_we;
`endif
      end
    end
  end

  // Storage is not reset; abort during SPLIT is handled because state drops to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
    if (rd_en) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (rd_hi_sel) rd_hi <= mem[rd_idx];
      else           rd_lo <= mem[rd_idx];
`else
      rd_lo <= mem[rd_idx];
`endif
    end
  end

  always_comb begin
    nb_q = 4'd1 << rsp_size_q;
`ifdef DMEM_MISALIGN_SPLIT_EN
    raw  = (rd_lo >> {rsp_off_q, 3'b000}) | (rd_hi << (DATA_W - 8 * int'(rsp_off_q)));
`else
    raw  = rd_lo >> {rsp_off_q, 3'b000};
`endif
    sign = 1'b0;
    for (int b = 0; b < NB; b++)
      if (b == int'(nb_q) - 1) sign = raw[8*b + 7];
    ext = !rsp_uns_q && sign;
    load_dat = '0;
    for (int b = 0; b < NB; b++)
      load_dat[8*b +: 8] = (b < int'(nb_q)) ? raw[8*b +: 8] : {8{ext}};
    rsp_rdata = (rsp_valid && !rsp_err_q && !rsp_we_q) ? load_dat : '0;
  end

  assign rsp_err = rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench: directed requests push expected responses; per-DUT monitors pop and compare on rsp_valid.
module tb_data_mem_sized;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_we, a_uns, a_rsp_valid, a_rsp_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rsp_rdata;
  logic        b_valid, b_ready, b_we, b_uns, b_rsp_valid, b_rsp_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rsp_rdata;

  data_mem_sized #(.DATA_W(32)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  data_mem_sized #(.DATA_W(64)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  typedef struct { logic err; logic [63:0] rdata; int cyc; } exp_t;
  exp_t  qa[$], qb[$];
  string qna[$], qnb[$];
  exp_t  ea, eb;
  string na, nb;
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && a_rsp_valid) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_spurious_rsp: got err=%0b rdata=%h at cyc %0d, want no response", a_rsp_err, a_rsp_rdata, cyc);
      end else begin
        ea = qa.pop_front();
        na = qna.pop_front();
        if (a_rsp_err !== ea.err || a_rsp_rdata !== ea.rdata[31:0] || cyc != ea.cyc) begin
          errors++;
          $display("FAIL %s: got err=%0b rdata=%h cyc=%0d, want err=%0b rdata=%h cyc=%0d",
                   na, a_rsp_err, a_rsp_rdata, cyc, ea.err, ea.rdata[31:0], ea.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rsp_valid) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_spurious_rsp: got err=%0b rdata=%h at cyc %0d, want no response", b_rsp_err, b_rsp_rdata, cyc);
      end else begin
        eb = qb.pop_front();
        nb = qnb.pop_front();
        if (b_rsp_err !== eb.err || b_rsp_rdata !== eb.rdata || cyc != eb.cyc) begin
          errors++;
          $display("FAIL %s: got err=%0b rdata=%h cyc=%0d, want err=%0b rdata=%h cyc=%0d",
                   nb, b_rsp_err, b_rsp_rdata, cyc, eb.err, eb.rdata, eb.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // lat = 0 issues the request without expecting any response.
  task automatic req(input bit b64, input string name, input bit we, input logic [1:0] size,
                     input bit uns, input logic [31:0] addr, input logic [63:0] wdata,
                     input bit xerr, input logic [63:0] xdata, input int lat);
    bit rdy;
    @(negedge clk);
    if (b64) begin
      b_valid = 1'b1; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
    end else begin
      a_valid = 1'b1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata[31:0];
    end
    rdy = 1'b0;
    for (int t = 0; t < 20; t++) begin
      rdy = b64 ? b_ready : a_ready;
      if (rdy) break;
      @(negedge clk);
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL %s: accept timeout, got req_ready=0 want 1", name);
      a_valid = 1'b0;
      b_valid = 1'b0;
      return;
    end
    if (lat > 0) begin
      if (b64) begin qb.push_back('{xerr, xdata, cyc + lat}); qnb.push_back(name); end
      else     begin qa.push_back('{xerr, xdata, cyc + lat}); qna.push_back(name); end
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    a_valid = 1'b0; a_we = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_valid = 1'b0; b_we = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = 32'h0; b_wdata = 64'h0;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("rst_rsp_rdata", 64'(a_rsp_rdata), 64'h0);
    chk("rst_rsp_err",   64'(a_rsp_err),   64'h0);
    chk("rst_ready",     64'(a_ready),     64'h0);
    rst = 1'b0;
    #1 chk("ready_before_edge", 64'(a_ready), 64'h0);
    @(negedge clk);
    chk("ready_after_edge", 64'(a_ready), 64'h1);
    chk("b_ready_after_edge", 64'(b_ready), 64'h1);

    // Aligned and sub-word accesses, store followed immediately by load
    req(0, "sw100",    1, 2'd2, 0, 32'h100, 64'hDEADBEEF, 0, 64'h0, 1);
    req(0, "lw100",    0, 2'd2, 0, 32'h100, 64'h0, 0, 64'hDEADBEEF, 1);
    req(0, "lbu103",   0, 2'd0, 1, 32'h103, 64'h0, 0, 64'h000000DE, 1);
    req(0, "lb101",    0, 2'd0, 0, 32'h101, 64'h0, 0, 64'hFFFFFFBE, 1);
    req(0, "lhu102",   0, 2'd1, 1, 32'h102, 64'h0, 0, 64'h0000DEAD, 1);
    req(0, "lh102",    0, 2'd1, 0, 32'h102, 64'h0, 0, 64'hFFFFDEAD, 1);
    req(0, "lbu100",   0, 2'd0, 1, 32'h100, 64'h0, 0, 64'h000000EF, 1);

    // Byte lanes
    req(0, "sw200",    1, 2'd2, 0, 32'h200, 64'h11223344, 0, 64'h0, 1);
    req(0, "sb201",    1, 2'd0, 0, 32'h201, 64'hFFFFFF5A, 0, 64'h0, 1);
    req(0, "lw200_sb", 0, 2'd2, 0, 32'h200, 64'h0, 0, 64'h11225A44, 1);
    req(0, "sh202",    1, 2'd1, 0, 32'h202, 64'h1234BEEF, 0, 64'h0, 1);
    req(0, "lw200_sh", 0, 2'd2, 0, 32'h200, 64'h0, 0, 64'hBEEF5A44, 1);
    req(0, "lhu201",   0, 2'd1, 1, 32'h201, 64'h0, 0, 64'h0000EF5A, 1);
    req(0, "lh201",    0, 2'd1, 0, 32'h201, 64'h0, 0, 64'hFFFFEF5A, 1);

    // Word-spanning accesses
    req(0, "sw104",    1, 2'd2, 0, 32'h104, 64'hCAFEF00D, 0, 64'h0, 1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    req(0, "lw_span102", 0, 2'd2, 0, 32'h102, 64'h0, 0, 64'hF00DDEAD, 2);
    chk("split_ready_low", 64'(a_ready), 64'h0);
    req(0, "sh_span103", 1, 2'd1, 0, 32'h103, 64'h7788, 0, 64'h0, 2);
    req(0, "lw100_span", 0, 2'd2, 0, 32'h100, 64'h0, 0, 64'h88ADBEEF, 1);
    req(0, "lw104_span", 0, 2'd2, 0, 32'h104, 64'h0, 0, 64'hCAFEF077, 1);
`else
    req(0, "lw_span102", 0, 2'd2, 0, 32'h102, 64'h0, 1, 64'h0, 1);
    chk("nosplit_ready_high", 64'(a_ready), 64'h1);
    req(0, "sh_span103", 1, 2'd1, 0, 32'h103, 64'h7788, 1, 64'h0, 1);
    req(0, "lw100_span", 0, 2'd2, 0, 32'h100, 64'h0, 0, 64'hDEADBEEF, 1);
    req(0, "lw104_span", 0, 2'd2, 0, 32'h104, 64'h0, 0, 64'hCAFEF00D, 1);
`endif

    // Range and size errors leave memory unchanged
    req(0, "sw0",        1, 2'd2, 0, 32'h0,        64'h55667788, 0, 64'h0, 1);
    req(0, "sw20000",    1, 2'd2, 0, 32'h20000,    64'h99999999, 1, 64'h0, 1);
    req(0, "sw80000000", 1, 2'd2, 0, 32'h80000000, 64'h99999999, 1, 64'h0, 1);
    req(0, "sd32_err",   1, 2'd3, 0, 32'h0,        64'h11111111, 1, 64'h0, 1);
    req(0, "ld32_err",   0, 2'd3, 0, 32'h0,        64'h0, 1, 64'h0, 1);
    req(0, "lw0_intact", 0, 2'd2, 0, 32'h0,        64'h0, 0, 64'h55667788, 1);
    req(0, "lh1ffff",    0, 2'd1, 0, 32'h1FFFF,    64'h0, 1, 64'h0, 1);
    req(0, "sw1fffc",    1, 2'd2, 0, 32'h1FFFC,    64'hA5A5C3C3, 0, 64'h0, 1);
    req(0, "lbu1ffff",   0, 2'd0, 1, 32'h1FFFF,    64'h0, 0, 64'h000000A5, 1);

`ifdef DMEM_MISALIGN_SPLIT_EN
    // Reset during SPLIT: first half kept, second half lost, no response
    req(0, "sw1fc",      1, 2'd2, 0, 32'h1FC, 64'h0, 0, 64'h0, 1);
    req(0, "sw_span1fe", 1, 2'd2, 0, 32'h1FE, 64'hAABBCCDD, 0, 64'h0, 0);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("abort_ready",     64'(a_ready),     64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready_before_edge", 64'(a_ready), 64'h0);
    @(negedge clk);
    chk("abort_ready_after_edge", 64'(a_ready), 64'h1);
    chk("abort_no_rsp", 64'(a_rsp_valid), 64'h0);
    req(0, "lw1fc_abort", 0, 2'd2, 0, 32'h1FC, 64'h0, 0, 64'hCCDD0000, 1);
    req(0, "lw200_abort", 0, 2'd2, 0, 32'h200, 64'h0, 0, 64'hBEEF5A44, 1);
`endif

    // 64-bit instance
    req(1, "sd8",       1, 2'd3, 0, 32'h8,     64'h0123456789ABCDEF, 0, 64'h0, 1);
    req(1, "lw_c",      0, 2'd2, 0, 32'hC,     64'h0, 0, 64'h0000000001234567, 1);
    req(1, "lwu_8",     0, 2'd2, 1, 32'h8,     64'h0, 0, 64'h0000000089ABCDEF, 1);
    req(1, "lw_8",      0, 2'd2, 0, 32'h8,     64'h0, 0, 64'hFFFFFFFF89ABCDEF, 1);
    req(1, "ld_8",      0, 2'd3, 0, 32'h8,     64'h0, 0, 64'h0123456789ABCDEF, 1);
    req(1, "ldu_8",     0, 2'd3, 1, 32'h8,     64'h0, 0, 64'h0123456789ABCDEF, 1);
    req(1, "lhu_e",     0, 2'd1, 1, 32'hE,     64'h0, 0, 64'h0000000000000123, 1);
    req(1, "sw_a",      1, 2'd2, 0, 32'hA,     64'hFFFFFFFF11223344, 0, 64'h0, 1);
    req(1, "ld_8_sw",   0, 2'd3, 0, 32'h8,     64'h0, 0, 64'h012311223344CDEF, 1);
    req(1, "ld_1fff9",  0, 2'd3, 0, 32'h1FFF9, 64'h0, 1, 64'h0, 1);

    for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 64'h0);
    chk("qb_drained", 64'(qb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
